// File: rtl/phase_realigner_if.sv
// Packet word bus into the phase realigner and the realigned block/header bus out of it.
// The master side drives packet words; the slave side is the realigner.
interface phase_realigner_if #(
  parameter int IDX_W = 8
);
  logic [288:0]     i_text;
  logic [0:3]       i_state;
  logic             i_ready;

  logic [127:0]     o_block;
  logic [160:0]     o_side;
  logic [IDX_W-1:0] o_blk_idx;
  logic             o_valid;
  logic             o_last;
  logic [111:0]     o_hdr;
  logic             o_hdr_valid;
  logic             o_err;

  modport master (
    output i_text, i_state, i_ready,
    input  o_block, o_side, o_blk_idx, o_valid, o_last, o_hdr, o_hdr_valid, o_err
  );

  modport slave (
    input  i_text, i_state, i_ready,
    output o_block, o_side, o_blk_idx, o_valid, o_last, o_hdr, o_hdr_valid, o_err
  );
endinterface

// File: rtl/phase_realigner.sv
// Strips the 16-bit phase offset from packet words and rebuilds word-aligned 128-bit cipher blocks.
// Optional macro PHASE_REALIGN_STATS_EN adds packet and error counters (o_pkt_cnt, o_err_cnt).
module phase_realigner #(
  parameter int OFFSET_W   = 16,
  parameter int IDX_W      = 8,
  parameter int MAX_BLOCKS = 255
) (
  input  logic clk,
  input  logic rst_n,
  phase_realigner_if.slave bus
`ifdef PHASE_REALIGN_STATS_EN
  ,
  output logic [31:0] o_pkt_cnt,
  output logic [15:0] o_err_cnt
`endif
);

  localparam int BODY_W = 128 - OFFSET_W;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_BLOCKS);

  localparam logic [3:0] ST_FIRST  = 4'd1;
  localparam logic [3:0] ST_SECOND = 4'd2;
  localparam logic [3:0] ST_INNER  = 4'd4;
  localparam logic [3:0] ST_LAST   = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  state_t              state_reg;
  logic [OFFSET_W-1:0] lo_reg;
  logic [IDX_W-1:0]    idx_reg;

  logic [127:0]        block_reg;
  logic [160:0]        side_reg;
  logic [IDX_W-1:0]    blk_idx_reg;
  logic                valid_reg;
  logic                last_reg;
  logic [BODY_W-1:0]   hdr_reg;
  logic                hdr_valid_reg;
  logic                err_reg;

  logic [127:0]        payload;
  logic [160:0]        side;
  logic [3:0]          word_type;
  logic                is_first;
  logic                is_mid;
  logic                is_last;

  assign payload   = bus.i_text[288:161];
  assign side      = bus.i_text[160:0];
  assign word_type = bus.i_state;
  assign is_first  = (word_type == ST_FIRST);
  assign is_mid    = (word_type == ST_SECOND) || (word_type == ST_INNER);
  assign is_last   = (word_type == ST_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      lo_reg        <= '0;
      idx_reg       <= '0;
      block_reg     <= '0;
      side_reg      <= '0;
      blk_idx_reg   <= '0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      hdr_reg       <= '0;
      hdr_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      hdr_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      if (bus.i_ready) begin
        if (is_first) begin
          // A FIRST inside a packet aborts it; the new packet still starts this cycle.
          err_reg       <= (state_reg == BODY);
          lo_reg        <= payload[127 -: OFFSET_W];
          hdr_reg       <= payload[BODY_W-1:0];
          hdr_valid_reg <= 1'b1;
          idx_reg       <= '0;
          state_reg     <= BODY;
        end else if (state_reg == IDLE) begin
          err_reg <= 1'b1;
        end else if ((is_mid || is_last) && (idx_reg != MAX_IDX)) begin
          block_reg   <= {payload[BODY_W-1:0], lo_reg};
          side_reg    <= side;
          blk_idx_reg <= idx_reg;
          valid_reg   <= 1'b1;
          if (is_last) begin
            last_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
            lo_reg  <= payload[127 -: OFFSET_W];
          end
        end else begin
          // Overrun or malformed word type: abandon the packet.
          err_reg   <= 1'b1;
          state_reg <= IDLE;
        end
      end
    end
  end

  assign bus.o_block     = block_reg;
  assign bus.o_side      = side_reg;
  assign bus.o_blk_idx   = blk_idx_reg;
  assign bus.o_valid     = valid_reg;
  assign bus.o_last      = last_reg;
  assign bus.o_hdr       = hdr_reg;
  assign bus.o_hdr_valid = hdr_valid_reg;
  assign bus.o_err       = err_reg;

`ifdef PHASE_REALIGN_STATS_EN
  logic [31:0] pkt_cnt_reg;
  logic [15:0] err_cnt_reg;

  // Counters follow the registered pulses, so they lag the pulse by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else begin
      if (valid_reg && last_reg) begin
        pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
      end
      if (err_reg && (err_cnt_reg != 16'hFFFF)) begin
        err_cnt_reg <= err_cnt_reg + 16'd1;
      end
    end
  end

  assign o_pkt_cnt = pkt_cnt_reg;
  assign o_err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_phase_realigner.sv
// Table-driven bench for phase_realigner: a default instance and a MAX_BLOCKS=2 instance share stimulus.
// Expected results are queued when a word is driven and compared when the DUT responds.
module tb_phase_realigner;

  localparam logic [3:0] F  = 4'd1;
  localparam logic [3:0] S2 = 4'd2;
  localparam logic [3:0] I  = 4'd4;
  localparam logic [3:0] L  = 4'd8;

  localparam logic [111:0] H1 = 112'h0123456789ABCDEF001122334455;
  localparam logic [111:0] H2 = 112'hFEDCBA98765432100F0E0D0C0B0A;

  typedef struct {
    logic         rst_before;
    logic [3:0]   st;
    logic         rdy;
    logic [127:0] p;
    logic         sm;
    logic         ev;
    logic [127:0] eb;
    logic [7:0]   ei;
    logic         el;
    logic         eh;
    logic [111:0] ehdr;
    logic         ee;
  } vec_t;

  typedef struct {
    vec_t         v;
    logic [160:0] side;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [288:0] text;
  logic [3:0]   state;
  logic         ready;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb[$];
  vec_t tab[0:31];
  logic [111:0] d[0:7];

  phase_realigner_if #(.IDX_W(8)) bus_a ();
  phase_realigner_if #(.IDX_W(8)) bus_b ();

  assign bus_a.i_text  = text;
  assign bus_a.i_state = state;
  assign bus_a.i_ready = ready;
  assign bus_b.i_text  = text;
  assign bus_b.i_state = state;
  assign bus_b.i_ready = ready;

`ifdef PHASE_REALIGN_STATS_EN
  logic [31:0] pkt_a, pkt_b;
  logic [15:0] errc_a, errc_b;
`endif

  phase_realigner #(.OFFSET_W(16), .IDX_W(8), .MAX_BLOCKS(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
`ifdef PHASE_REALIGN_STATS_EN
    ,
    .o_pkt_cnt (pkt_a),
    .o_err_cnt (errc_a)
`endif
  );

  phase_realigner #(.OFFSET_W(16), .IDX_W(8), .MAX_BLOCKS(2)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
`ifdef PHASE_REALIGN_STATS_EN
    ,
    .o_pkt_cnt (pkt_b),
    .o_err_cnt (errc_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [288:0] act, input logic [288:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] st, input logic rdy, input logic [127:0] p,
                              input logic sm, input logic ev, input logic [127:0] eb,
                              input logic [7:0] ei, input logic el, input logic eh,
                              input logic [111:0] ehdr, input logic ee);
    vec_t v;
    v.rst_before = 1'b0;
    v.st = st; v.rdy = rdy; v.p = p; v.sm = sm;
    v.ev = ev; v.eb = eb; v.ei = ei; v.el = el;
    v.eh = eh; v.ehdr = ehdr; v.ee = ee;
    return v;
  endfunction

  task automatic reset_pulse();
    @(negedge clk);
    ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 289'(bus_a.o_valid), 289'(0));
    chk("rst_async_block", 289'(bus_a.o_block), 289'(0));
    chk("rst_async_idx",   289'(bus_a.o_blk_idx), 289'(0));
    chk("rst_async_hdr",   289'(bus_a.o_hdr), 289'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input int n, input vec_t v);
    exp_t e;
    logic [160:0] s;
    logic a_valid, a_last, a_hdr_valid, a_err;
    logic [127:0] a_block;
    logic [160:0] a_side;
    logic [7:0]   a_idx;
    logic [111:0] a_hdr;
    @(negedge clk);
    s = {1'b1, $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    text  = {v.p, s};
    state = v.st;
    ready = v.rdy;
    e.v = v;
    e.side = s;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 289'(1), 289'(0));
      return;
    end
    e = sb.pop_front();
    if (e.v.sm) begin
      a_valid = bus_b.o_valid; a_last = bus_b.o_last; a_hdr_valid = bus_b.o_hdr_valid;
      a_err = bus_b.o_err; a_block = bus_b.o_block; a_side = bus_b.o_side;
      a_idx = bus_b.o_blk_idx; a_hdr = bus_b.o_hdr;
    end else begin
      a_valid = bus_a.o_valid; a_last = bus_a.o_last; a_hdr_valid = bus_a.o_hdr_valid;
      a_err = bus_a.o_err; a_block = bus_a.o_block; a_side = bus_a.o_side;
      a_idx = bus_a.o_blk_idx; a_hdr = bus_a.o_hdr;
    end
    chk($sformatf("v%0d_valid", n), 289'(a_valid), 289'(e.v.ev));
    chk($sformatf("v%0d_last", n), 289'(a_last), 289'(e.v.el));
    chk($sformatf("v%0d_hdr_valid", n), 289'(a_hdr_valid), 289'(e.v.eh));
    chk($sformatf("v%0d_err", n), 289'(a_err), 289'(e.v.ee));
    if (e.v.ev) begin
      chk($sformatf("v%0d_block", n), 289'(a_block), 289'(e.v.eb));
      chk($sformatf("v%0d_idx", n), 289'(a_idx), 289'(e.v.ei));
      chk($sformatf("v%0d_side", n), 289'(a_side), 289'(e.side));
    end
    if (e.v.eh) begin
      chk($sformatf("v%0d_hdr", n), 289'(a_hdr), 289'(e.v.ehdr));
    end
    $display("[TB] word %0d state=%0d ready=%0b valid=%0b idx=%0d last=%0b hdr_valid=%0b err=%0b",
             n, v.st, v.rdy, a_valid, a_idx, a_last, a_hdr_valid, a_err);
  endtask

  initial begin
    logic [3:0] k4;
    rst_n = 1'b0;
    text  = '0;
    state = '0;
    ready = 1'b0;

    for (int k = 0; k < 8; k++) begin
      k4 = 4'(k + 1);
      d[k] = {28{k4}};
    end

    // Basic packet, FIRST->LAST, ready gap, IDLE error, abort, malformed types.
    tab[0]  = mk(F,  1, {16'hAAAA, H1},   0, 0, '0,                   0, 0, 1, H1, 0);
    tab[1]  = mk(I,  1, {16'hBBBB, d[0]}, 0, 1, {d[0], 16'hAAAA},     0, 0, 0, '0, 0);
    tab[2]  = mk(L,  1, {16'h0000, d[1]}, 0, 1, {d[1], 16'hBBBB},     1, 1, 0, '0, 0);
    tab[3]  = mk(F,  1, {16'hCCCC, H2},   0, 0, '0,                   0, 0, 1, H2, 0);
    tab[4]  = mk(L,  1, {16'h0000, d[2]}, 0, 1, {d[2], 16'hCCCC},     0, 1, 0, '0, 0);
    tab[5]  = mk(F,  1, {16'h1111, H1},   0, 0, '0,                   0, 0, 1, H1, 0);
    tab[6]  = mk(S2, 1, {16'h2222, d[3]}, 0, 1, {d[3], 16'h1111},     0, 0, 0, '0, 0);
    tab[7]  = mk(I,  0, {16'hFFFF, d[6]}, 0, 0, '0,                   0, 0, 0, '0, 0);
    tab[8]  = mk(L,  0, {16'hFFFF, d[6]}, 0, 0, '0,                   0, 0, 0, '0, 0);
    tab[9]  = mk(F,  0, {16'hFFFF, d[6]}, 0, 0, '0,                   0, 0, 0, '0, 0);
    tab[10] = mk(I,  1, {16'h3333, d[4]}, 0, 1, {d[4], 16'h2222},     1, 0, 0, '0, 0);
    tab[11] = mk(L,  1, {16'h0000, d[5]}, 0, 1, {d[5], 16'h3333},     2, 1, 0, '0, 0);
    tab[12] = mk(I,  1, {16'h4444, d[0]}, 0, 0, '0,                   0, 0, 0, '0, 1);
    tab[13] = mk(F,  1, {16'h5555, H2},   0, 0, '0,                   0, 0, 1, H2, 0);
    tab[14] = mk(L,  1, {16'h0000, d[1]}, 0, 1, {d[1], 16'h5555},     0, 1, 0, '0, 0);
    tab[15] = mk(F,  1, {16'h6666, H1},   0, 0, '0,                   0, 0, 1, H1, 0);
    tab[16] = mk(I,  1, {16'h7777, d[2]}, 0, 1, {d[2], 16'h6666},     0, 0, 0, '0, 0);
    tab[17] = mk(F,  1, {16'h8888, H2},   0, 0, '0,                   0, 0, 1, H2, 1);
    tab[18] = mk(I,  1, {16'h9999, d[3]}, 0, 1, {d[3], 16'h8888},     0, 0, 0, '0, 0);
    tab[19] = mk(L,  1, {16'h0000, d[4]}, 0, 1, {d[4], 16'h9999},     1, 1, 0, '0, 0);
    tab[20] = mk(F,  1, {16'hABCD, H1},   0, 0, '0,                   0, 0, 1, H1, 0);
    tab[21] = mk(4'b0011, 1, {16'h1212, d[5]}, 0, 0, '0,              0, 0, 0, '0, 1);
    tab[22] = mk(I,  1, {16'h1234, d[0]}, 0, 0, '0,                   0, 0, 0, '0, 1);
    tab[23] = mk(4'b0000, 1, {16'h4321, d[1]}, 0, 0, '0,              0, 0, 0, '0, 1);
    tab[24] = mk(F,  1, {16'h0F0F, H2},   0, 0, '0,                   0, 0, 1, H2, 0);
    tab[25] = mk(I,  1, {16'hF0F0, d[5]}, 0, 1, {d[5], 16'h0F0F},     0, 0, 0, '0, 0);
    // After a mid-packet reset the FSM is IDLE: a LAST only errors.
    tab[26] = mk(L,  1, {16'h0000, d[6]}, 0, 0, '0,                   0, 0, 0, '0, 1);
    tab[26].rst_before = 1'b1;
    // Overrun on the MAX_BLOCKS=2 instance.
    tab[27] = mk(F,  1, {16'h1357, H1},   1, 0, '0,                   0, 0, 1, H1, 0);
    tab[27].rst_before = 1'b1;
    tab[28] = mk(I,  1, {16'h2468, d[0]}, 1, 1, {d[0], 16'h1357},     0, 0, 0, '0, 0);
    tab[29] = mk(I,  1, {16'h3579, d[1]}, 1, 1, {d[1], 16'h2468},     1, 0, 0, '0, 0);
    tab[30] = mk(I,  1, {16'h468A, d[2]}, 1, 0, '0,                   0, 0, 0, '0, 1);
    tab[31] = mk(L,  1, {16'h0000, d[3]}, 1, 0, '0,                   0, 0, 0, '0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid",     289'(bus_a.o_valid),     289'(0));
    chk("reset_last",      289'(bus_a.o_last),      289'(0));
    chk("reset_hdr_valid", 289'(bus_a.o_hdr_valid), 289'(0));
    chk("reset_err",       289'(bus_a.o_err),       289'(0));
    chk("reset_block",     289'(bus_a.o_block),     289'(0));
    chk("reset_side",      289'(bus_a.o_side),      289'(0));
    chk("reset_idx",       289'(bus_a.o_blk_idx),   289'(0));
    chk("reset_hdr",       289'(bus_a.o_hdr),       289'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 32; n++) begin
      if (tab[n].rst_before) reset_pulse();
      apply(n, tab[n]);
    end

    @(negedge clk);
    ready = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_no_valid", 289'(bus_b.o_valid), 289'(0));
    chk("idle_no_err",   289'(bus_b.o_err),   289'(0));
`ifdef PHASE_REALIGN_STATS_EN
    chk("stats_err_cnt", 289'(errc_b), 289'(2));
    chk("stats_pkt_cnt", 289'(pkt_b),  289'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
